// File: rtl/fifo_test_pkg.sv
// Shared definitions for the FIFO test traffic blocks (stream generator and checker).
// Holds the throttle LFSR polynomial, its default seed and the common run-state encoding.
package fifo_test_pkg;

    localparam int unsigned LFSR_W = 16;

    // Tap mask for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10)
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hACE1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/fifo_stream_checker_if.sv
// Control, FIFO read-port and status bundle of the stream checker.
// master is the checker side, slave is the environment (FIFO plus controller).
interface fifo_stream_checker_if #(
    parameter int unsigned DW    = 16,
    parameter int unsigned CNT_W = 32
);

    logic             start_i;
    logic [CNT_W-1:0] num_txn_i;
    logic [DW-1:0]    seed_i;
    logic [7:0]       rate_i;

    logic             rd_en_o;
    logic [DW-1:0]    rd_data_i;
    logic             empty_i;

    logic             busy_o;
    logic             done_o;
    logic             pass_o;
    logic [CNT_W-1:0] err_cnt_o;
    logic [CNT_W-1:0] rd_cnt_o;
    logic [CNT_W-1:0] first_err_idx_o;
    logic [DW-1:0]    first_err_exp_o;
    logic [DW-1:0]    first_err_got_o;

    modport master (
        input  start_i, num_txn_i, seed_i, rate_i, rd_data_i, empty_i,
        output rd_en_o, busy_o, done_o, pass_o, err_cnt_o, rd_cnt_o,
               first_err_idx_o, first_err_exp_o, first_err_got_o
    );

    modport slave (
        output start_i, num_txn_i, seed_i, rate_i, rd_data_i, empty_i,
        input  rd_en_o, busy_o, done_o, pass_o, err_cnt_o, rd_cnt_o,
               first_err_idx_o, first_err_exp_o, first_err_got_o
    );

endinterface

// File: rtl/fifo_test_lfsr.sv
// 16-bit Fibonacci throttle LFSR with synchronous load-to-seed and step enable.
// Load has priority over enable; reset also returns to the seed.
module fifo_test_lfsr
    import fifo_test_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    output logic [LFSR_W-1:0] value
);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = SEED;
        end else if (en) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/fifo_stream_checker.sv
// Read-side FIFO traffic consumer: drains the FIFO at an LFSR-throttled rate and checks
// every word against an incrementing sequence, reporting error count and first mismatch.
module fifo_stream_checker
    import fifo_test_pkg::*;
#(
    parameter int unsigned       DW        = 16,
    parameter int unsigned       CNT_W     = 32,
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    fifo_stream_checker_if.master bus
);

    state_e state_q, state_d;

    logic [CNT_W-1:0] num_q;
    logic [7:0]       rate_q;
    logic [CNT_W-1:0] issued_q;
    logic             cmp_v_q;
    logic [DW-1:0]    exp_q;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] first_idx_q;
    logic [DW-1:0]    first_exp_q;
    logic [DW-1:0]    first_got_q;

    logic              launch;
    logic              permit;
    logic              mismatch;
    logic              rd_en;
    logic              busy;
    logic              done;
    logic [LFSR_W-1:0] lfsr_val;
    logic              unused_lfsr_hi;

    // Start is only honoured outside RUN
    assign launch   = bus.start_i & (state_q != StRun);
    assign permit   = lfsr_val[7:0] <= rate_q;
    assign mismatch = cmp_v_q & (bus.rd_data_i != exp_q);
    assign rd_cnt_d = rd_cnt_q + CNT_W'(cmp_v_q);

    assign unused_lfsr_hi = ^lfsr_val[LFSR_W-1:8];

    fifo_test_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk_i),
        .rst   (rst_i),
        .load  (launch),
        .en    (state_q == StRun),
        .value (lfsr_val)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Leave RUN on the edge that retires the final compare, so done rises right after it
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start_i) state_d = StRun;
            end
            StRun: begin
                if (rd_cnt_d == num_q) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_en = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (state_q)
            StRun: begin
                busy  = 1'b1;
                rd_en = !bus.empty_i && permit && (issued_q < num_q);
            end
            StDone: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            num_q       <= '0;
            rate_q      <= '0;
            issued_q    <= '0;
            cmp_v_q     <= 1'b0;
            exp_q       <= '0;
            rd_cnt_q    <= '0;
            err_cnt_q   <= '0;
            first_idx_q <= '0;
            first_exp_q <= '0;
            first_got_q <= '0;
        end else begin
            cmp_v_q <= rd_en;
            if (launch) begin
                num_q       <= bus.num_txn_i;
                rate_q      <= bus.rate_i;
                exp_q       <= bus.seed_i;
                issued_q    <= '0;
                rd_cnt_q    <= '0;
                err_cnt_q   <= '0;
                first_idx_q <= '0;
                first_exp_q <= '0;
                first_got_q <= '0;
            end else begin
                if (rd_en) begin
                    issued_q <= issued_q + CNT_W'(1);
                end
                if (cmp_v_q) begin
                    exp_q    <= exp_q + DW'(1);
                    rd_cnt_q <= rd_cnt_d;
                end
                if (mismatch) begin
                    if (err_cnt_q != '1) begin
                        err_cnt_q <= err_cnt_q + CNT_W'(1);
                    end
                    // A zero count means this is the first mismatch of the run
                    if (err_cnt_q == '0) begin
                        first_idx_q <= rd_cnt_q;
                        first_exp_q <= exp_q;
                        first_got_q <= bus.rd_data_i;
                    end
                end
            end
        end
    end

    assign bus.rd_en_o         = rd_en;
    assign bus.busy_o          = busy;
    assign bus.done_o          = done;
    assign bus.pass_o          = done & (err_cnt_q == '0);
    assign bus.err_cnt_o       = err_cnt_q;
    assign bus.rd_cnt_o        = rd_cnt_q;
    assign bus.first_err_idx_o = first_idx_q;
    assign bus.first_err_exp_o = first_exp_q;
    assign bus.first_err_got_o = first_got_q;

endmodule

// File: tb/tb_fifo_stream_checker.sv
// Scoreboard bench for fifo_stream_checker: a queue-based FIFO model feeds the checker, a
// per-cycle read-enable model and end-of-run result records are compared by a monitor.
module tb_fifo_stream_checker;

    localparam int unsigned DW    = 16;
    localparam int unsigned CNT_W = 32;
    localparam logic [15:0] LSEED = 16'hACE1;

    typedef struct {
        int unsigned err;
        int unsigned idx;
        logic [15:0] exp;
        logic [15:0] got;
        int unsigned cnt;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_stream_checker_if #(.DW(DW), .CNT_W(CNT_W)) bus ();

    fifo_stream_checker #(
        .DW        (DW),
        .CNT_W     (CNT_W),
        .LFSR_SEED (LSEED)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    res_t        res_q[$];
    logic [15:0] fifo_q[$];
    logic [15:0] src_q[$];
    bit          force_empty = 0;
    bit          pend = 0;
    logic [15:0] nxt_data = '0;
    longint      cyc = 0;

    // Reference model of the run in progress
    bit          m_run = 0;
    logic [15:0] m_lfsr = LSEED;
    int          m_issued = 0;
    int          m_num = 0;
    logic [7:0]  m_rate = 0;
    longint      exp_done_cyc = -1;
    longint      first_rd_cyc = -1;
    longint      last_rd_cyc = -1;
    longint      done_cyc = -1;
    bit          done_prev = 0;
    bit          measure = 0;
    int          elig_cnt = 0;
    int          rden_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, req);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic res_t model(input logic [15:0] seed, input int num);
        res_t r;
        r = '{default: 0};
        for (int i = 0; i < num; i++) begin
            logic [15:0] e;
            e = seed + 16'(i);
            if (src_q[i] !== e) begin
                if (r.err == 0) begin
                    r.idx = i;
                    r.exp = e;
                    r.got = src_q[i];
                end
                r.err++;
            end
        end
        r.cnt = num;
        return r;
    endfunction

    // FIFO model: data popped on a read appears on rd_data the following cycle
    initial begin
        bus.empty_i   = 1'b1;
        bus.rd_data_i = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (pend) begin
                bus.rd_data_i = nxt_data;
                pend = 0;
            end
            bus.empty_i = force_empty || (fifo_q.size() == 0);
        end
    end

    // Monitor: per-cycle read-enable model, FIFO pops and end-of-run scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                logic exp_rd;
                res_t r;
                exp_rd = m_run && !bus.empty_i && (m_lfsr[7:0] <= m_rate) && (m_issued < m_num);
                check("rd_en", bus.rd_en_o, exp_rd);
                if (bus.rd_en_o) begin
                    check("rd_en_while_empty", bus.empty_i, 1'b0);
                    if (fifo_q.size() > 0) nxt_data = fifo_q.pop_front();
                    pend = 1;
                    if (first_rd_cyc < 0) first_rd_cyc = cyc;
                    last_rd_cyc = cyc;
                end
                if (measure && m_run && !bus.empty_i && (m_issued < m_num)) begin
                    elig_cnt++;
                    if (bus.rd_en_o) rden_cnt++;
                end
                if (m_run) begin
                    if (exp_rd) begin
                        m_issued++;
                        if (m_issued == m_num) exp_done_cyc = cyc + 2;
                    end
                    m_lfsr = lfsr_step(m_lfsr);
                end
                if (bus.done_o && !done_prev) begin
                    m_run = 0;
                    done_cyc = cyc;
                    check("done_time", cyc, exp_done_cyc);
                    if (res_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done at cycle %0d: got done, want none", cyc);
                    end else begin
                        r = res_q.pop_front();
                        check("err_cnt", bus.err_cnt_o, r.err);
                        check("rd_cnt", bus.rd_cnt_o, r.cnt);
                        check("pass", bus.pass_o, r.err == 0);
                        check("first_idx", bus.first_err_idx_o, r.idx);
                        check("first_exp", bus.first_err_exp_o, r.exp);
                        check("first_got", bus.first_err_got_o, r.got);
                    end
                end
                done_prev = bus.done_o;
            end
        end
    end

    task automatic launch(input logic [15:0] seed, input int num, input logic [7:0] rate);
        first_rd_cyc   = -1;
        bus.seed_i     = seed;
        bus.num_txn_i  = num;
        bus.rate_i     = rate;
        bus.start_i    = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        m_run    = 1;
        m_lfsr   = LSEED;
        m_issued = 0;
        m_num    = num;
        m_rate   = rate;
        if (num == 0) exp_done_cyc = cyc + 1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        res_q.delete();
        fifo_q.delete();
        m_run = 0;
        pend = 0;
        done_prev = 0;
        force_empty = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Full run over src_q; trickle_pct=0 pre-fills the FIFO, otherwise words arrive randomly
    task automatic run(input logic [15:0] seed, input int num, input logic [7:0] rate,
                       input int trickle_pct, input int hold_at, input int hold_len);
        int n = 0;
        int si = 0;
        res_q.push_back(model(seed, num));
        if (trickle_pct == 0) begin
            foreach (src_q[i]) fifo_q.push_back(src_q[i]);
            si = src_q.size();
            @(posedge clk);
            #1;
        end
        launch(seed, num, rate);
        while (!bus.done_o && n < 3000) begin
            force_empty = (n >= hold_at) && (n < hold_at + hold_len);
            if (si < src_q.size() && $urandom_range(99) < trickle_pct) begin
                fifo_q.push_back(src_q[si]);
                si++;
            end
            @(posedge clk);
            #1;
            n++;
        end
        force_empty = 0;
        if (!bus.done_o) begin
            checks++;
            errors++;
            $display("FAIL run_timeout at cycle %0d: got no done, want done", cyc);
            apply_reset();
        end
        @(posedge clk);
        #1;
        fifo_q.delete();
    endtask

    task automatic fill_seq(input logic [15:0] seed, input int num);
        src_q.delete();
        for (int i = 0; i < num; i++) src_q.push_back(seed + 16'(i));
    endtask

    initial begin
        bus.start_i   = 1'b0;
        bus.num_txn_i = '0;
        bus.seed_i    = '0;
        bus.rate_i    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy_o, 0);
        check("rst_done", bus.done_o, 0);
        check("rst_pass", bus.pass_o, 0);
        check("rst_err", bus.err_cnt_o, 0);
        check("rst_rd_cnt", bus.rd_cnt_o, 0);
        rst = 1'b0;

        // Back-to-back drain of ten words at full rate
        fill_seq(16'h0000, 10);
        run(16'h0000, 10, 8'd255, 0, 1 << 30, 0);
        check("first_to_done", done_cyc - first_rd_cyc, 11);
        check("burst_len", last_rd_cyc - first_rd_cyc, 9);

        // Single corrupted word
        src_q = '{16'd0, 16'd1, 16'd2, 16'd7, 16'd4};
        run(16'h0000, 5, 8'd255, 0, 1 << 30, 0);
        check("t2_idx", bus.first_err_idx_o, 3);
        check("t2_exp", bus.first_err_exp_o, 3);
        check("t2_got", bus.first_err_got_o, 7);
        check("t2_pass", bus.pass_o, 0);

        // Sequence wrap-around
        fill_seq(16'hFFFE, 4);
        run(16'hFFFE, 4, 8'd255, 0, 1 << 30, 0);
        check("wrap_pass", bus.pass_o, 1);

        // Empty held mid-run at quarter rate
        fill_seq(16'h1234, 40);
        measure = 1;
        elig_cnt = 0;
        rden_cnt = 0;
        run(16'h1234, 40, 8'd64, 0, 30, 20);
        measure = 0;
        check("duty_in_range",
              (rden_cnt * 100 >= elig_cnt * 12) && (rden_cnt * 100 <= elig_cnt * 40), 1);
        check("empty_pass", bus.pass_o, 1);

        // Reset after three reads of ten
        fill_seq(16'h0000, 10);
        foreach (src_q[i]) fifo_q.push_back(src_q[i]);
        res_q.push_back(model(16'h0000, 10));
        @(posedge clk);
        #1;
        launch(16'h0000, 10, 8'd255);
        for (int k = 0; k < 50 && m_issued < 3; k++) begin
            @(posedge clk);
            #1;
        end
        check("reads_before_rst", m_issued, 3);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", bus.busy_o, 0);
        check("mid_rst_rd_en", bus.rd_en_o, 0);
        check("mid_rst_rd_cnt", bus.rd_cnt_o, 0);
        check("mid_rst_err", bus.err_cnt_o, 0);
        check("mid_rst_idx", bus.first_err_idx_o, 0);
        apply_reset();
        check("post_rst_rd_en", bus.rd_en_o, 0);
        fill_seq(16'h0500, 5);
        run(16'h0500, 5, 8'd255, 0, 1 << 30, 0);
        check("post_rst_pass", bus.pass_o, 1);

        // Zero-length run with a start pulse while busy
        src_q.delete();
        res_q.push_back(model(16'h0000, 0));
        launch(16'h0000, 0, 8'd255);
        check("zero_busy", bus.busy_o, 1);
        bus.num_txn_i = 5;
        bus.start_i   = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        check("zero_done", bus.done_o, 1);
        check("zero_pass", bus.pass_o, 1);
        @(posedge clk);
        #1;

        // Randomised runs with trickled data and occasional corruption
        for (int t = 0; t < 8; t++) begin
            logic [15:0] sd;
            int          num;
            sd  = 16'($urandom);
            num = $urandom_range(30, 1);
            fill_seq(sd, num);
            if ($urandom_range(99) < 40) begin
                int j;
                j = $urandom_range(num - 1);
                src_q[j] = src_q[j] ^ (16'($urandom_range(16'hFFFF, 1)));
            end
            run(sd, num, 8'($urandom_range(255)), 60, $urandom_range(40), $urandom_range(15));
        end

        check("scoreboard_drained", res_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
